// File: rtl/pll_clken_pkg.sv
// Shared types for the fractional clock-enable generator.
// Lock FSM states and the per-channel rate configuration bundle.
package pll_clken_pkg;

  // Widest supported accumulator; narrower ACC_W values are zero-extended.
  localparam int unsigned CFG_W = 32;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_e;

  typedef struct packed {
    logic [CFG_W-1:0] num;
    logic [CFG_W-1:0] den;
`ifdef PLL_CLKEN_PHASE_EN
    logic [CFG_W-1:0] phase;
`endif
  } ch_cfg_t;

endpackage

// File: rtl/pll_clken_ch.sv
// One fractional accumulator channel: NUM/DEN/ACC registers and strobe.
// Ports: clk, rst_n, en_i (accumulate), load_i (apply cfg_i), cfg_i, clken_o.
// PLL_CLKEN_PHASE_EN: accumulator restarts from cfg.phase instead of 0.
module pll_clken_ch
  import pll_clken_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en_i,
  input  logic    load_i,
  input  ch_cfg_t cfg_i,
  output logic    clken_o
);

  ch_cfg_t          cfg_q, cfg_d;
  logic [CFG_W-1:0] acc_q, acc_d;
  logic [CFG_W:0]   sum_w;
  logic             clken_q, clken_d;

  always_comb begin
    sum_w   = {1'b0, acc_q} + {1'b0, cfg_q.num};
    cfg_d   = cfg_q;
    acc_d   = acc_q;
    clken_d = 1'b0;
    if (load_i) begin
      cfg_d = cfg_i;
`ifdef PLL_CLKEN_PHASE_EN
      acc_d = cfg_i.phase;
`else
      acc_d = '0;
`endif
    end else if (!en_i) begin
      // Idle: hold the start point so RUN entry begins from it.
`ifdef PLL_CLKEN_PHASE_EN
      acc_d = cfg_q.phase;
`else
      acc_d = '0;
`endif
    end else if (sum_w >= {1'b0, cfg_q.den}) begin
      acc_d   = CFG_W'(sum_w - {1'b0, cfg_q.den});
      clken_d = 1'b1;
    end else begin
      acc_d = sum_w[CFG_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q.num   <= '0;
      cfg_q.den   <= CFG_W'(1);
`ifdef PLL_CLKEN_PHASE_EN
      cfg_q.phase <= '0;
`endif
      acc_q       <= '0;
      clken_q     <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      acc_q       <= acc_d;
      clken_q     <= clken_d;
    end
  end

  assign clken_o = clken_q;

endmodule

// File: rtl/pll_clken_gen.sv
// Multi-channel fractional clock-enable generator gated on PLL lock.
// Ports: clk, rst_n, pll_locked (async), cfg_valid/ready/ch/num/den,
//   cfg_err pulse, clken[NUM_CH] strobes, running.
// PLL_CLKEN_PHASE_EN adds cfg_phase (initial accumulator per channel).
module pll_clken_gen
  import pll_clken_pkg::*;
#(
  parameter  int unsigned NUM_CH    = 4,
  parameter  int unsigned ACC_W     = 24,
  parameter  int unsigned LOCK_WAIT = 1024,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
`ifdef PLL_CLKEN_PHASE_EN
  input  logic [ACC_W-1:0]  cfg_phase,
`endif
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clken,
  output logic              running
);

  localparam int unsigned CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

  logic             lk_meta_q, lk_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q;
  logic             cfg_ready_q, cfg_err_q;
  logic             accept_w, bad_w, apply_w, run_en_w;
  ch_cfg_t          cfg_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_s_q    <= lk_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (!lk_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lk_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Lock loss drops the enable on the same edge that leaves RUN.
  assign run_en_w = (state_q == RUN) && lk_s_q;

  assign accept_w = cfg_valid && cfg_ready_q;
  assign bad_w = (cfg_den == '0)
              || (cfg_num > cfg_den)
              || ({1'b0, cfg_ch} >= (CH_W + 1)'(NUM_CH))
`ifdef PLL_CLKEN_PHASE_EN
              || (cfg_phase >= cfg_den)
`endif
              ;
  assign apply_w = accept_w && !bad_w;

  always_comb begin
    cfg_w.num   = CFG_W'(cfg_num);
    cfg_w.den   = CFG_W'(cfg_den);
`ifdef PLL_CLKEN_PHASE_EN
    cfg_w.phase = CFG_W'(cfg_phase);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      running_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      running_q   <= (state_d == RUN);
      // One accept per two cycles: ready drops right after each accept.
      cfg_ready_q <= !accept_w;
      cfg_err_q   <= accept_w && bad_w;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_clken_ch u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (run_en_w),
      .load_i  (apply_w && (cfg_ch == CH_W'(i))),
      .cfg_i   (cfg_w),
      .clken_o (clken[i])
    );
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign running   = running_q;

endmodule

// File: tb/tb_pll_clken_gen.sv
// Randomised scoreboard bench for pll_clken_gen.
// Cycle model pushes expected outputs; a negedge monitor pops and compares.
module tb_pll_clken_gen;

  localparam int NCH = 5;
  localparam int AW  = 24;
  localparam int LW  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pll_locked = 1'b0;
  logic           cfg_valid = 1'b0;
  logic [2:0]     cfg_ch = '0;
  logic [AW-1:0]  cfg_num = '0;
  logic [AW-1:0]  cfg_den = 24'd1;
  logic [AW-1:0]  cfg_ph = '0;
  logic           cfg_ready, cfg_err, running;
  logic [NCH-1:0] clken;

  int tests = 0;
  int fails = 0;

  pll_clken_gen #(
    .NUM_CH    (NCH),
    .ACC_W     (AW),
    .LOCK_WAIT (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_num    (cfg_num),
    .cfg_den    (cfg_den),
`ifdef PLL_CLKEN_PHASE_EN
    .cfg_phase  (cfg_ph),
`endif
    .cfg_err    (cfg_err),
    .clken      (clken),
    .running    (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] clken;
    logic           run;
    logic           rdy;
    logic           err;
  } exp_t;

  exp_t q[$];

  // Reference: strobes after k enabled cycles = floor((k*NUM+PHASE)/DEN).
  function automatic longint cum(longint k, longint n, longint d, longint p);
    return (k * n + p) / d;
  endfunction

  longint mnum[NCH], mden[NCH], mph[NCH], mk[NCH];
  bit     mrdy, h0, h1;
  int     streak;

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    bit lks, en, acc, bad;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < NCH; i++) begin
        mnum[i] = 0; mden[i] = 1; mph[i] = 0; mk[i] = 0;
      end
      mrdy = 0; h0 = 0; h1 = 0; streak = 0;
    end else begin
      // lock seen by the FSM is pll_locked from two edges earlier
      lks = h1; h1 = h0; h0 = pll_locked;
      streak = lks ? streak + 1 : 0;
      en = (streak >= LW + 1);
      acc = cfg_valid && mrdy;
      bad = (cfg_den == 0) || (cfg_num > cfg_den) || (cfg_ch >= NCH);
`ifdef PLL_CLKEN_PHASE_EN
      bad = bad || (cfg_ph >= cfg_den);
`endif
      e.clken = '0;
      for (int i = 0; i < NCH; i++) begin
        if (acc && !bad && (cfg_ch == 3'(i))) begin
          mnum[i] = cfg_num; mden[i] = cfg_den; mk[i] = 0;
`ifdef PLL_CLKEN_PHASE_EN
          mph[i] = cfg_ph;
`endif
        end else if (!en) begin
          mk[i] = 0;
        end else begin
          mk[i]++;
          e.clken[i] = cum(mk[i], mnum[i], mden[i], mph[i]) >
                       cum(mk[i] - 1, mnum[i], mden[i], mph[i]);
        end
      end
      e.run = (streak >= LW);
      e.rdy = !acc;
      e.err = acc && bad;
      mrdy = !acc;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (clken !== e.clken || running !== e.run ||
          cfg_ready !== e.rdy || cfg_err !== e.err) begin
        fails++;
        $display("FAIL sb t=%0t clken=%b exp %b run=%b exp %b rdy=%b exp %b err=%b exp %b",
                 $time, clken, e.clken, running, e.run, cfg_ready, e.rdy, cfg_err, e.err);
      end
    end
  end

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(string nm, longint act, longint lo, longint hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic cfg(input int ch, input int n, input int d, input int ph,
                     output bit err, output bit r1, output bit r2);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = 3'(ch);
    cfg_num = AW'(n); cfg_den = AW'(d); cfg_ph = AW'(ph);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    err = cfg_err; r1 = cfg_ready;
    @(posedge clk); #1;
    r2 = cfg_ready;
  endtask

  task automatic chk_rst(string nm);
    chk({nm, "_clken"}, clken, 0);
    chk({nm, "_run"}, running, 0);
    chk({nm, "_rdy"}, cfg_ready, 0);
    chk({nm, "_err"}, cfg_err, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit err, r1, r2;
    int rise, fall, last0, minp, maxp;
    int cnt[NCH];
    int d2, n2;

    repeat (3) @(posedge clk);
    #1 chk_rst("reset");

    // lock at t0, running rises after sync (2) + LOCK_WAIT cycles
    @(posedge clk); #1;
    rst_n = 1'b1; pll_locked = 1'b1;
    rise = -1;
    for (int n = 1; n <= 40 && rise < 0; n++) begin
      @(posedge clk); #1;
      if (running) rise = n;
    end
    chk_rng("lock_rise", rise, 17, 19);

    d2 = $urandom_range(50, 1);
    n2 = $urandom_range(d2, 0);
    cfg(0, 1, 3, 0, err, r1, r2); chk("cfg0_err", err, 0);
    cfg(1, 2, 5, 0, err, r1, r2);
    cfg(2, n2, d2, 0, err, r1, r2);
    cfg(3, 7, 7, 0, err, r1, r2);
    cfg(4, 0, 9, 0, err, r1, r2);
    repeat (5) @(posedge clk);

    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    last0 = -1; minp = 1000000; maxp = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) if (clken[i]) cnt[i]++;
      if (clken[0]) begin
        if (last0 >= 0) begin
          if (c - last0 < minp) minp = c - last0;
          if (c - last0 > maxp) maxp = c - last0;
        end
        last0 = c;
      end
    end
    chk("ch0_min_period", minp, 3);
    chk("ch0_max_period", maxp, 3);
    chk("ch1_count", cnt[1], 400);
    chk_rng("ch2_count", cnt[2], (1000 * n2) / d2 - 1, (1000 * n2) / d2 + 1);
    chk("ch3_full", cnt[3], 1000);
    chk("ch4_zero", cnt[4], 0);

    // rejected requests: consumed, one-cycle error, no state change
    cfg(0, 1, 0, 0, err, r1, r2);
    chk("rej_den0_err", err, 1);
    chk("rej_den0_rdy", r1, 0);
    cfg(1, 9, 8, 0, err, r1, r2);
    chk("rej_num_gt_den", err, 1);
    cfg(NCH, 1, 2, 0, err, r1, r2);
    chk("rej_ch_range", err, 1);
    cnt[1] = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (clken[1]) cnt[1]++;
    end
    chk("ch1_after_rej", cnt[1], 40);

    // reconfigure ch2 while others run: ready low exactly one cycle
    cfg(2, 1, 2, 0, err, r1, r2);
    chk("recfg_err", err, 0);
    chk("recfg_rdy_low", r1, 0);
    chk("recfg_rdy_back", r2, 1);
    repeat (20) @(posedge clk);

    // one-cycle lock glitch
    @(posedge clk); #1 pll_locked = 1'b0;
    fall = -1; rise = -1;
    for (int n = 1; n <= 40 && rise < 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) pll_locked = 1'b1;
      if (fall < 0 && !running) begin
        fall = n;
        chk("drop_clken", clken, 0);
      end else if (fall > 0 && running) begin
        rise = n;
      end
    end
    chk_rng("drop_fall", fall, 1, 3);
    chk("drop_reentry", rise - fall, LW);

    // randomised configs and occasional lock drops
    for (int it = 0; it < 30; it++) begin
      int ch, d, n, ph;
      ch = $urandom_range(NCH, 0);
      d  = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(40, 1);
      n  = $urandom_range(d + 1, 0);
      ph = (d > 0) ? $urandom_range(d, 0) : 0;
      cfg(ch, n, d, ph, err, r1, r2);
      if ($urandom_range(7, 0) == 0) begin
        @(posedge clk); #1 pll_locked = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1 pll_locked = 1'b1;
      end
      repeat ($urandom_range(30, 3)) @(posedge clk);
    end

    // asynchronous reset mid-run
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk_rst("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
